debounce_array: RTL and testbench

- Multi-channel, parametrised input conditioner for board-level switches, buttons and sensor contacts in the anti-theft controller.
- Each channel has its own synchroniser, stable-time counter and registered clean level.
- Each channel also emits single-cycle rise/fall strobes, so downstream FSMs need no local edge detectors.
- Sits between the raw pins and all control logic; one instance serves every contact input.

---
 rtl/debounce_pkg.sv | 31 +++
 rtl/debounce_array_if.sv | 14 +
 rtl/debounce_channel.sv | 94 +++++++++
 rtl/debounce_array.sv | 65 ++++++
 tb/tb_debounce_array.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce_array input conditioner: width helper,
// 100 MHz timing defaults and the per-channel status bundle.
package debounce_pkg;

  // Bits needed to hold values 0 .. value-1 (never less than 1).
  function automatic int clog2(input int unsigned value);
    int unsigned v;
    int          w;
    v = (value > 1) ? value - 1 : 0;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if (v != 0) begin
        w++;
        v = v >> 1;
      end
    end
    return (w < 1) ? 1 : w;
  endfunction

  localparam int unsigned CLK_HZ      = 100_000_000;
  localparam int unsigned STABLE_10MS = CLK_HZ / 100;
  localparam int unsigned LONG_1S     = CLK_HZ;

  typedef struct packed {
    logic clean;
    logic rise;
    logic fall;
    logic long_press;
  } chan_status_t;

endpackage

// File: rtl/debounce_array_if.sv
// Contact-input bundle: raw pins in, debounced levels and strobes out.
interface debounce_array_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] noisy;
  logic [CHANNELS-1:0] clean;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic                any_change;
  logic [CHANNELS-1:0] long_press;

  modport master (output noisy, input clean, rise, fall, any_change, long_press);
  modport slave  (input noisy, output clean, rise, fall, any_change, long_press);
endinterface

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser, stable-time counter, clean register,
// rise/fall strobes. Defining DEBOUNCE_LONG_PRESS_EN adds a long-hold counter
// that pulses long_press once per press; otherwise long_press is tied low.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_10MS,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic        RESET_VAL     = 1'b0,
  parameter int unsigned LONG_CYCLES   = LONG_1S
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         noisy,
  output chan_status_t status,
  output logic         change_next
);
  localparam int CNT_W = clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   candidate;
  logic [CNT_W-1:0]       count_q;
  logic                   clean_q;
  logic                   clean_next;
  logic                   rise_q;
  logic                   fall_q;
  logic                   long_q;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser shift register; only its last stage is used downstream.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= {SYNC_STAGES{RESET_VAL}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], noisy};
  end

  // Accept the candidate only when it has matched for the full saturated count.
  always_comb begin
    clean_next = clean_q;
    if (s == candidate && count_q == CNT_MAX) clean_next = candidate;
  end

  assign change_next = clean_next ^ clean_q;

  // Candidate tracking, saturating stable counter, clean level and edge strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      candidate <= RESET_VAL;
      count_q   <= '0;
      clean_q   <= RESET_VAL;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      if (s != candidate) begin
        candidate <= s;
        count_q   <= '0;
      end else if (count_q != CNT_MAX) begin
        count_q <= count_q + 1'b1;
      end
      clean_q <= clean_next;
      rise_q  <= clean_next & ~clean_q;
      fall_q  <= ~clean_next & clean_q;
    end
  end

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int LONG_W = clog2(LONG_CYCLES);
  localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_FIRE = LONG_W'(LONG_CYCLES - 2);

  logic [LONG_W-1:0] long_cnt_q;

  // Long-hold counter: saturates so each press yields a single pulse; cleared while released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      long_cnt_q <= '0;
      long_q     <= 1'b0;
    end else if (!clean_q || rise_q) begin
      long_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      if (long_cnt_q != LONG_MAX) long_cnt_q <= long_cnt_q + 1'b1;
      long_q <= (long_cnt_q == LONG_FIRE);
    end
  end
`else
  assign long_q = 1'b0;
`endif

  assign status = chan_status_t'({clean_q, rise_q, fall_q, long_q});

endmodule

// File: rtl/debounce_array.sv
// Multi-channel contact debouncer: one debounce_channel per input plus a
// registered any_change summary. DEBOUNCE_LONG_PRESS_EN enables long_press.
module debounce_array
  import debounce_pkg::*;
#(
  parameter int          CHANNELS      = 4,
  parameter int unsigned STABLE_CYCLES = STABLE_10MS,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic        RESET_VAL     = 1'b0,
  parameter int unsigned LONG_CYCLES   = LONG_1S
) (
  input logic             clock,
  input logic             reset,
  debounce_array_if.slave bus
);
  chan_status_t [CHANNELS-1:0] status;
  logic [CHANNELS-1:0]         change_next;
  logic [CHANNELS-1:0]         clean_v;
  logic [CHANNELS-1:0]         rise_v;
  logic [CHANNELS-1:0]         fall_v;
  logic [CHANNELS-1:0]         long_v;
  logic                        any_change_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES),
      .RESET_VAL     (RESET_VAL),
      .LONG_CYCLES   (LONG_CYCLES)
    ) u_chan (
      .clock       (clock),
      .reset       (reset),
      .noisy       (bus.noisy[i]),
      .status      (status[i]),
      .change_next (change_next[i])
    );
  end

  // Fan the per-channel status bundles out to the port vectors.
  always_comb begin
    clean_v = '0;
    rise_v  = '0;
    fall_v  = '0;
    long_v  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      clean_v[i] = status[i].clean;
      rise_v[i]  = status[i].rise;
      fall_v[i]  = status[i].fall;
      long_v[i]  = status[i].long_press;
    end
  end

  // Registered from the channels' next-edge flags so it lines up with the strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) any_change_q <= 1'b0;
    else       any_change_q <= |change_next;
  end

  assign bus.clean      = clean_v;
  assign bus.rise       = rise_v;
  assign bus.fall       = fall_v;
  assign bus.long_press = long_v;
  assign bus.any_change = any_change_q;

endmodule

// File: tb/tb_debounce_array.sv
// Bench for debounce_array: directed scenarios followed by random toggling,
// every cycle compared against a sliding-window reference model.
module tb_debounce_array;
  import debounce_pkg::*;

  localparam int   CH  = 4;
  localparam int   ST  = 4;
  localparam int   SS  = 2;
  localparam int   LC  = 16;
  localparam logic RV  = 1'b0;
  localparam int   WIN = SS + ST + 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  debounce_array_if #(.CHANNELS(CH)) dif ();

  debounce_array #(
    .CHANNELS      (CH),
    .STABLE_CYCLES (ST),
    .SYNC_STAGES   (SS),
    .RESET_VAL     (RV),
    .LONG_CYCLES   (LC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (dif.slave)
  );

  always #5 clock = ~clock;

  // reference model: clean follows a value once the last ST+1 synchronised samples all agree
  logic [CH-1:0] hist [WIN];
  logic [CH-1:0] m_clean, m_rise, m_fall, m_long;
  logic          m_any;
  int            age [CH];
  int            edge_n = 0;

  int first_rise [CH];
  int first_fall [CH];
  int first_long [CH];
  int n_rise [CH];
  int n_fall [CH];
  int n_long [CH];
  int n_any;

  task automatic model_reset();
    for (int k = 0; k < WIN; k++) hist[k] = {CH{RV}};
    m_clean = {CH{RV}};
    m_rise  = '0;
    m_fall  = '0;
    m_long  = '0;
    m_any   = 1'b0;
    for (int c = 0; c < CH; c++) age[c] = 0;
  endtask

  task automatic model_edge(input logic [CH-1:0] smp);
    logic [CH-1:0] prev;
    prev = m_clean;
    for (int k = WIN - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = smp;
    for (int c = 0; c < CH; c++) begin
      int ones;
      ones = 0;
      for (int k = SS; k < WIN; k++) ones += int'(hist[k][c]);
      if (ones == WIN - SS) m_clean[c] = 1'b1;
      else if (ones == 0)   m_clean[c] = 1'b0;
    end
    m_rise = m_clean & ~prev;
    m_fall = ~m_clean & prev;
    m_any  = |(m_rise | m_fall);
    m_long = '0;
`ifdef DEBOUNCE_LONG_PRESS_EN
    for (int c = 0; c < CH; c++) begin
      if (prev[c]) age[c]++;
      if (prev[c] && age[c] == LC) m_long[c] = 1'b1;
      if (m_rise[c] || !m_clean[c]) age[c] = 0;
    end
`endif
  endtask

  task automatic clear_track();
    for (int c = 0; c < CH; c++) begin
      first_rise[c] = -1;
      first_fall[c] = -1;
      first_long[c] = -1;
      n_rise[c] = 0;
      n_fall[c] = 0;
      n_long[c] = 0;
    end
    n_any = 0;
  endtask

  task automatic check_outputs(input string tag);
    checks++;
    assert (dif.clean === m_clean) else begin
      errors++; $error("FAIL %s clean observed=%h expected=%h", tag, dif.clean, m_clean);
    end
    checks++;
    assert (dif.rise === m_rise) else begin
      errors++; $error("FAIL %s rise observed=%h expected=%h", tag, dif.rise, m_rise);
    end
    checks++;
    assert (dif.fall === m_fall) else begin
      errors++; $error("FAIL %s fall observed=%h expected=%h", tag, dif.fall, m_fall);
    end
    checks++;
    assert (dif.any_change === m_any) else begin
      errors++; $error("FAIL %s any_change observed=%b expected=%b", tag, dif.any_change, m_any);
    end
    checks++;
    assert (dif.long_press === m_long) else begin
      errors++; $error("FAIL %s long_press observed=%h expected=%h", tag, dif.long_press, m_long);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    edge_n++;
    if (reset) model_reset();
    else       model_edge(dif.noisy);
    #1;
    check_outputs(tag);
    for (int c = 0; c < CH; c++) begin
      if (dif.rise[c] === 1'b1) begin
        n_rise[c]++;
        if (first_rise[c] < 0) first_rise[c] = edge_n;
      end
      if (dif.fall[c] === 1'b1) begin
        n_fall[c]++;
        if (first_fall[c] < 0) first_fall[c] = edge_n;
      end
      if (dif.long_press[c] === 1'b1) begin
        n_long[c]++;
        if (first_long[c] < 0) first_long[c] = edge_n;
      end
    end
    if (dif.any_change === 1'b1) n_any++;
  endtask

  task automatic assert_reset(input string tag);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs(tag);
  endtask

  task automatic release_reset();
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int          e;
    int          lp_exp;
    logic [5:0]  bounce;
    int          hold [CH];

    dif.noisy = '0;
    model_reset();
    clear_track();

    // power-on reset
    assert_reset("por");
    repeat (3) step("por_hold");
    release_reset();

    // drive every channel high, then reset asynchronously between edges
    dif.noisy = 4'hF;
    repeat (10) step("settle_high");
    assert_reset("rst_async");
    clear_track();
    repeat (4) step("rst_hold");
    chk_int("rst_hold_no_any", n_any, 0);
    chk_int("rst_hold_no_rise", n_rise[0] + n_rise[1] + n_rise[2] + n_rise[3], 0);

    // steady RESET_VAL after release: no strobes
    dif.noisy = '0;
    release_reset();
    clear_track();
    repeat (8) step("idle_after_rst");
    chk_int("idle_no_strobe", n_any, 0);

    // single step on channel 0
    clear_track();
    dif.noisy[0] = 1'b1;
    e = edge_n + 1;
    repeat (10) step("ch0_step");
    chk_int("ch0_rise_edge", first_rise[0], e + 6);
    chk_int("ch0_rise_count", n_rise[0], 1);
    chk_int("ch0_any_count", n_any, 1);
    chk_int("ch0_others_quiet", n_rise[1] + n_rise[2] + n_rise[3], 0);

    // 4-cycle pulse on channel 1 is rejected
    clear_track();
    dif.noisy[1] = 1'b1;
    repeat (4) step("ch1_pulse4");
    dif.noisy[1] = 1'b0;
    repeat (10) step("ch1_pulse4_after");
    chk_int("pulse4_no_rise", n_rise[1], 0);
    chk_int("pulse4_no_fall", n_fall[1], 0);

    // 5-cycle pulse on channel 1 is accepted
    clear_track();
    dif.noisy[1] = 1'b1;
    e = edge_n + 1;
    repeat (5) step("ch1_pulse5");
    dif.noisy[1] = 1'b0;
    repeat (12) step("ch1_pulse5_after");
    chk_int("pulse5_rise_edge", first_rise[1], e + 6);
    chk_int("pulse5_fall_gap", first_fall[1] - first_rise[1], 5);

    // bounce on channel 2 before holding high
    clear_track();
    bounce = 6'b101101;
    for (int i = 5; i >= 0; i--) begin
      dif.noisy[2] = bounce[i];
      e = edge_n + 1;
      step("ch2_bounce");
    end
    repeat (10) step("ch2_hold");
    chk_int("bounce_rise_edge", first_rise[2], e + 6);
    chk_int("bounce_rise_count", n_rise[2], 1);

    // simultaneous steps on channels 1 and 3
    clear_track();
    dif.noisy[1] = 1'b1;
    dif.noisy[3] = 1'b1;
    e = edge_n + 1;
    repeat (10) step("ch13_step");
    chk_int("ch13_same_edge", first_rise[1], first_rise[3]);
    chk_int("ch13_rise_edge", first_rise[3], e + 6);
    chk_int("ch13_any_once", n_any, 1);

    // reset while channel 1 is mid-count
    dif.noisy[1] = 1'b0;
    repeat (10) step("ch1_drop");
    clear_track();
    dif.noisy[1] = 1'b1;
    repeat (5) step("ch1_count2");
    chk_int("midcount_no_rise", n_rise[1], 0);
    assert_reset("rst_mid_count");
    repeat (2) step("rst_mid_hold");
    clear_track();
    release_reset();
    e = edge_n + 1;
    repeat (40) step("after_mid_rst");
    chk_int("fresh_count_ch1", first_rise[1], e + 6);
    chk_int("fresh_count_ch0", first_rise[0], e + 6);

    // long press on channel 0 (continues the hold from the release above)
`ifdef DEBOUNCE_LONG_PRESS_EN
    lp_exp = 1;
    chk_int("long_edge", first_long[0], first_rise[0] + LC);
`else
    lp_exp = 0;
`endif
    chk_int("long_count_first", n_long[0], lp_exp);
    dif.noisy[0] = 1'b0;
    repeat (12) step("ch0_release");
    dif.noisy[0] = 1'b1;
    repeat (40) step("ch0_repress");
    chk_int("long_count_second", n_long[0], 2 * lp_exp);

    // random toggling with random hold times, one async reset in the middle
    for (int c = 0; c < CH; c++) hold[c] = 1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int c = 0; c < CH; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          dif.noisy[c] = ~dif.noisy[c];
          hold[c] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 30))
                                                 : int'($urandom_range(1, 8));
        end
      end
      if (cyc == 700) begin
        assert_reset("rand_rst");
        step("rand_rst_hold");
        release_reset();
      end
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
